// File: rtl/note_player.sv
// note_player -- single-voice square-wave note generator.
//
// Accepts a note (pitch code, octave shift, duration in ticks) over a
// valid/ready handshake. It then plays a square wave on `tone` for the
// requested number of duration ticks and returns to idle with a one-cycle
// `done` pulse.
//
// Build option:
//   NOTE_PLAYER_GAP_EN  when defined, a silent GAP of GAP_TICKS ticks
//                       follows every note before the block returns to
//                       idle. When undefined, PLAY goes straight to IDLE.
//
// Ports:
//   clk         single clock
//   rst         asynchronous active-high reset
//   note_valid  a note request is present
//   note_ready  high in IDLE; a note is taken when valid && ready at clk
//   note_code   0..6 = do,re,mi,fa,sol,la,si; 7 = rest
//   octave      upward octave shift (half-period >> octave)
//   duration    note length in ticks (0 is treated as 1)
//   tone        square-wave audio output
//   busy        high whenever not in IDLE
//   done        one-cycle pulse in the first IDLE cycle after a note
module note_player #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned OCT_W     = 2,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [2:0]       note_code,
  input  logic [OCT_W-1:0] octave,
  input  logic [DUR_W-1:0] duration,
  output logic             tone,
  output logic             busy,
  output logic             done
);

  // Half period in clock cycles for a frequency given in tenths of a Hz.
  // The result is floor(CLK_FREQ / (2 * f)).
  function automatic longint unsigned half_period(input longint unsigned f10);
    return (longint'(CLK_FREQ) * 64'd10) / (64'd2 * f10);
  endfunction

  // Clock cycles per duration tick (guarded against a zero ratio).
  localparam int unsigned TPT_RAW = CLK_FREQ / TICK_HZ;
  localparam int unsigned TPT     = (TPT_RAW == 0) ? 1 : TPT_RAW;
  localparam int unsigned PRE_W   = (TPT > 1) ? $clog2(TPT) : 1;

  // Gap length; a zero request still needs one tick to leave the state.
  localparam int unsigned GAP_EFF = (GAP_TICKS == 0) ? 1 : GAP_TICKS;
  localparam int unsigned GAP_W   = $clog2(GAP_EFF + 1);
  localparam int unsigned TICK_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  // "do" is the lowest pitch, so it has the longest half period. That
  // value sets the width of the half-period counter.
  localparam longint unsigned HP_MAX = half_period(64'd2616);
  localparam int unsigned     HP_W   = $clog2(HP_MAX + 1);

  localparam logic [HP_W-1:0] HP_DO  = HP_W'(half_period(64'd2616));
  localparam logic [HP_W-1:0] HP_RE  = HP_W'(half_period(64'd2936));
  localparam logic [HP_W-1:0] HP_MI  = HP_W'(half_period(64'd3296));
  localparam logic [HP_W-1:0] HP_FA  = HP_W'(half_period(64'd3492));
  localparam logic [HP_W-1:0] HP_SOL = HP_W'(half_period(64'd3920));
  localparam logic [HP_W-1:0] HP_LA  = HP_W'(half_period(64'd4400));
  localparam logic [HP_W-1:0] HP_SI  = HP_W'(half_period(64'd4938));

  localparam logic [2:0] CODE_REST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1
`ifdef NOTE_PLAYER_GAP_EN
    ,
    GAP  = 2'd2
`endif
  } state_t;

  state_t state;
  state_t next_state;

  logic              done_r;
  logic [PRE_W-1:0]  pre_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [HP_W-1:0]   hp_cnt;
  logic              tone_r;

  // Note fields latched at acceptance.
  logic [2:0]        code_q;
  logic [OCT_W-1:0]  oct_q;
  logic [DUR_W-1:0]  dur_q;

  logic              accept;
  logic              pre_wrap;
  logic              seg_end;
  logic [TICK_W-1:0] end_ticks;
  logic [HP_W-1:0]   hp_base;
  logic [HP_W-1:0]   hp_shift;
  logic [HP_W-1:0]   hp_eff;

  assign accept   = note_valid && note_ready;
  assign pre_wrap = (pre_cnt == PRE_W'(TPT - 1));

  // Tick count that ends the current segment (the note itself, or the gap).
  always_comb begin
    end_ticks = TICK_W'(dur_q);
`ifdef NOTE_PLAYER_GAP_EN
    if (state == GAP) begin
      end_ticks = TICK_W'(GAP_EFF);
    end
`endif
  end

  // The last clock cycle of the final tick of the current segment.
  assign seg_end = pre_wrap && (tick_cnt == (end_ticks - TICK_W'(1)));

  // Effective half period. Large octave shifts that reduce it to zero are
  // clamped to 1, so the tone then toggles every cycle.
  always_comb begin
    hp_base = '0;
    case (code_q)
      3'd0:    hp_base = HP_DO;
      3'd1:    hp_base = HP_RE;
      3'd2:    hp_base = HP_MI;
      3'd3:    hp_base = HP_FA;
      3'd4:    hp_base = HP_SOL;
      3'd5:    hp_base = HP_LA;
      3'd6:    hp_base = HP_SI;
      default: hp_base = '0;
    endcase
    hp_shift = hp_base >> oct_q;
    hp_eff   = (hp_shift == '0) ? HP_W'(1) : hp_shift;
  end

  // State register. done_r marks the first IDLE cycle after a note. A
  // reset lands in IDLE with done_r clear, so an abandoned note is silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_r <= 1'b0;
    end else begin
      state  <= next_state;
      done_r <= (state != IDLE) && (next_state == IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = PLAY;
        end
      end
      PLAY: begin
        if (seg_end) begin
`ifdef NOTE_PLAYER_GAP_EN
          next_state = GAP;
`else
          next_state = IDLE;
`endif
        end
      end
`ifdef NOTE_PLAYER_GAP_EN
      GAP: begin
        if (seg_end) begin
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Outputs. tone_r is gated so that it cannot leak into the first IDLE
  // cycle after a note that ended on a high half-cycle.
  always_comb begin
    note_ready = (state == IDLE);
    busy       = (state != IDLE);
    done       = done_r;
    tone       = (state == PLAY) && tone_r;
  end

  // Datapath: tick prescaler, tick counter, half-period counter, tone.
  // Every counter restarts at zero on acceptance, so note timing does not
  // depend on earlier history. The segment end also zeroes the tick
  // counters, which leaves them ready for GAP or for IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
      hp_cnt   <= '0;
      tone_r   <= 1'b0;
      code_q   <= '0;
      oct_q    <= '0;
      dur_q    <= '0;
    end else if (accept) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
      hp_cnt   <= '0;
      tone_r   <= 1'b0;
      code_q   <= note_code;
      oct_q    <= octave;
      dur_q    <= (duration == '0) ? DUR_W'(1) : duration;
    end else if (state != IDLE) begin
      if (pre_wrap) begin
        pre_cnt  <= '0;
        tick_cnt <= seg_end ? '0 : (tick_cnt + TICK_W'(1));
      end else begin
        pre_cnt  <= pre_cnt + PRE_W'(1);
      end

      if ((state == PLAY) && (code_q != CODE_REST)) begin
        if (hp_cnt == (hp_eff - HP_W'(1))) begin
          hp_cnt <= '0;
          tone_r <= ~tone_r;
        end else begin
          hp_cnt <= hp_cnt + HP_W'(1);
        end
      end else begin
        hp_cnt <= '0;
        tone_r <= 1'b0;
      end
    end else begin
      hp_cnt <= '0;
      tone_r <= 1'b0;
    end
  end

endmodule
